adder_arbiter: RTL and testbench

- Round-robin arbiter sharing the single 64-bit combinational adder between N_REQ requesters: PC increment, ALU add, and stack-pointer update.
- Latches the winning operands and drives the adder with enable high for exactly one cycle.
- Registers Sum/OF and returns them to the winner over a valid/ready response handshake.
- The adder itself sits outside this block; it is connected through the add_* ports.

---
 rtl/adder_arbiter.sv | 127 ++++++++++++
 tb/tb_adder_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one external combinational adder between
// N_REQ requesters, issuing one add at a time and returning Sum/OF over valid/ready.
module adder_arbiter #(
  parameter int WIDTH = 64,
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_en,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_of,
  output logic [N_REQ-1:0]       resp_valid,
  input  logic [N_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]       resp_sum,
  output logic                   resp_of,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] rr_ptr, rr_next;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] scan_idx;
  logic [PTR_W:0]   scan_sum;
  logic             grant_found;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] op_a, op_b;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin : grant_scan
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(N_REQ)) scan_sum = scan_sum - (PTR_W+1)'(N_REQ);
      scan_idx = scan_sum[PTR_W-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Constant-index mux keeps the operand select free of variable part-selects.
  always_comb begin : operand_select
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rr_next = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + PTR_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin : next_state
    state_next = state;
    case (state)
      IDLE:    if (grant_found) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (resp_ready[winner]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the operand holding registers are reset too, so add_a/add_b and the
  // response path never expose stale data after an abandoned transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      winner   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      resp_sum <= '0;
      resp_of  <= 1'b0;
    end else begin
      if (state == IDLE && grant_found) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        winner <= grant_idx;
        rr_ptr <= rr_next;
      end
      if (state == ISSUE) begin
        resp_sum <= add_sum;
        resp_of  <= add_of;
      end
    end
  end

  // req_ready is combinational from req_valid, so it is gated by rst_n to
  // stay low while reset is held.
  always_comb begin : handshake_out
    req_ready  = '0;
    resp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i]  = rst_n && (state == IDLE) && grant_found && (grant_idx == PTR_W'(i));
      resp_valid[i] = (state == RESP) && (winner == PTR_W'(i));
    end
  end

  assign add_en = (state == ISSUE);
  assign add_a  = add_en ? op_a : '0;
  assign add_b  = add_en ? op_b : '0;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus random traffic,
// checked each cycle against a transaction-level model of the arbiter.
module tb_adder_arbiter;

  localparam int W = 64;
  localparam int N = 3;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   add_a, add_b, add_sum;
  logic           add_en, add_of;
  logic [N-1:0]   resp_valid, resp_ready;
  logic [W-1:0]   resp_sum;
  logic           resp_of;
  logic           busy;

  adder_arbiter #(.WIDTH(W), .N_REQ(N), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_en(add_en),
    .add_sum(add_sum), .add_of(add_of),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_of(resp_of), .busy(busy)
  );

  // External adder: plain sum, overflow when like-signed operands give an unlike-signed result.
  assign add_sum = add_a + add_b;
  assign add_of  = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Transaction-level model: phase 0 = waiting, 1 = adding, 2 = answering.
  int           m_phase = 0;
  int           m_rr    = 0;
  int           m_win   = 0;
  logic [W-1:0] m_a, m_b, m_sum;
  logic         m_of;
  int           cyc      = 0;
  int           last_win = -1;
  logic [N-1:0] seen_ready;

  function automatic logic [W-1:0] rand64();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic set_ops(input int who, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[who*W +: W] = a;
    req_b[who*W +: W] = b;
  endtask

  // One clock: compare at the falling edge, advance the model, then retire the granted request.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    logic [64:0]  wide;
    int           w;
    int           idx;
    @(negedge clk);
    cyc++;
    exp_ready = '0;
    w = -1;
    if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (w < 0 && req_valid[idx]) w = idx;
      end
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    seen_ready = req_ready;
    check("req_ready", req_ready, exp_ready);
    check("busy", busy, m_phase != 0);
    check("add_en", add_en, m_phase == 1);
    check("add_a", add_a, (m_phase == 1) ? m_a : '0);
    check("add_b", add_b, (m_phase == 1) ? m_b : '0);
    check("resp_valid", resp_valid, (m_phase == 2) ? (64'd1 << m_win) : 64'd0);
    if (m_phase == 2) begin
      check("resp_sum", resp_sum, m_sum);
      check("resp_of", resp_of, m_of);
    end
    last_win = -1;
    case (m_phase)
      0: if (w >= 0) begin
        m_win    = w;
        m_a      = req_a[w*W +: W];
        m_b      = req_b[w*W +: W];
        m_rr     = (w + 1) % N;
        m_phase  = 1;
        last_win = w;
      end
      1: begin
        wide    = {m_a[W-1], m_a} + {m_b[W-1], m_b};
        m_sum   = m_a + m_b;
        m_of    = wide[64] ^ wide[63];
        m_phase = 2;
      end
      default: if (resp_ready[m_win]) m_phase = 0;
    endcase
    @(posedge clk);
    #1;
    if (last_win >= 0) req_valid[last_win] = 1'b0;
  endtask

  task automatic drain();
    req_valid  = '0;
    resp_ready = '1;
    repeat (8) cycle();
    resp_ready = '0;
  endtask

  // Single request with optional response stall; checks the known sum/OF at RESP entry.
  task automatic txn(input int who, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int stall, input logic [W-1:0] exp_sum, input logic exp_of);
    logic [N-1:0] me;
    me = '0;
    me[who] = 1'b1;
    set_ops(who, a, b);
    req_valid  = me;
    resp_ready = '0;
    cycle();
    cycle();
    check("txn_valid", resp_valid, me);
    check("txn_sum", resp_sum, exp_sum);
    check("txn_of", resp_of, exp_of);
    repeat (stall) begin
      resp_ready = ~me;
      req_valid  = ~me;
      cycle();
    end
    resp_ready = me;
    cycle();
    resp_ready = '0;
    cycle();
  endtask

  initial begin
    int g, last_cyc;
    logic [N-1:0] exp_grant;
    rst_n      = 1'b0;
    req_valid  = '1;
    resp_ready = '1;
    for (int i = 0; i < N; i++) set_ops(i, rand64(), rand64());

    // Reset state, with requests already pending.
    #3;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_sum", resp_sum, 0);
    check("rst_resp_of", resp_of, 0);
    check("rst_add_en", add_en, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All requesters held valid from reset with resp_ready high: 0,1,2,0,1,2,0 at 3-cycle spacing.
    g = 0;
    last_cyc = 0;
    for (int c = 0; c < 40 && g < 7; c++) begin
      cycle();
      if (last_win >= 0) begin
        exp_grant = '0;
        exp_grant[g % N] = 1'b1;
        check("rr_order", seen_ready, exp_grant);
        if (g > 0) check("rr_spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
        g++;
        set_ops(last_win, rand64(), rand64());
        req_valid = '1;
      end
    end
    check("rr_grants", g, 7);
    drain();

    // Directed sums, overflow corners and a 5-cycle response stall.
    txn(1, 64'd5, 64'd7, 0, 64'd12, 1'b0);
    txn(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5, 64'h8000_0000_0000_0000, 1'b1);
    drain();
    txn(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd0, 1'b0);
    drain();

    // Asynchronous reset while the add is being issued.
    set_ops(2, 64'd100, 64'd23);
    req_valid = 3'b100;
    cycle();
    check("pre_rst_add_en", add_en, 1);
    req_valid = '1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_add_en", add_en, 0);
    check("mid_rst_add_a", add_a, 0);
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_resp_sum", resp_sum, 0);
    m_phase = 0;
    m_rr    = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    resp_ready = '1;
    cycle();
    check("post_rst_grant", seen_ready, 3'b001);
    drain();

    // Quiet period: the adder must stay gated off.
    req_valid = '0;
    repeat (10) cycle();

    // Random traffic: requests held until granted, random response backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_ops(i, rand64(), rand64());
          req_valid[i] = 1'b1;
        end
      end
      resp_ready = N'($urandom());
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
